pipe_hazard_unit: RTL



---
 rtl/pipe_hazard_unit_pkg.sv | 26 ++
 rtl/pipe_hazard_unit_if.sv | 37 +++
 rtl/pipe_hazard_unit_hazard_match.sv | 50 +++++
 rtl/pipe_hazard_unit.sv | 85 ++++++++
 4 files changed

// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: scoreboard entry layout,
// forwarding-select encoding and a small helper to build select codes.
package pipe_hazard_unit_pkg;

    // Register index width stored in an entry; wide enough for up to 256 registers.
    localparam int RD_W = 8;

    // Select value meaning "read operand from the register file".
    localparam int FWD_REGFILE = 0;

    // One in-flight instruction tracked by the scoreboard.
    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            wen;
        logic            is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    // Forwarding from entry k is encoded as k+1 so that 0 stays "regfile".
    function automatic int fwd_sel_of(input int k);
        return k + 1;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// ID-stage to hazard-unit bundle: decoded operand info in, stall/forward
// controls and statistics out.
interface pipe_hazard_unit_if #(
    parameter int NREG   = 32,
    parameter int DEPTH  = 3,
    parameter int REG_AW = $clog2(NREG),
    parameter int SEL_W  = $clog2(DEPTH + 1)
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_wen;
    logic              id_is_load;
    logic              flush;
    logic              stall;
    logic [SEL_W-1:0]  fwd_sel_rs1;
    logic [SEL_W-1:0]  fwd_sel_rs2;
    logic              issue;
    logic [31:0]       stall_count;

    // Decode stage side
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_wen, id_is_load, flush,
        input  stall, fwd_sel_rs1, fwd_sel_rs2, issue, stall_count
    );

    // Hazard unit side
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_wen, id_is_load, flush,
        output stall, fwd_sel_rs1, fwd_sel_rs2, issue, stall_count
    );
endinterface

// File: rtl/pipe_hazard_unit_hazard_match.sv
// Per-operand priority search over the scoreboard: finds the youngest
// in-flight writer of the operand and decides forward vs. hazard.
module hazard_match
    import pipe_hazard_unit_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int FWD_EN     = 1,
    parameter int LOAD_READY = 1,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  sb_entry_t [DEPTH-1:0] i_sb,
    input  logic [RD_W-1:0]       i_rs,
    input  logic                  i_used,
    input  logic                  i_valid,
    output logic [SEL_W-1:0]      o_sel,
    output logic                  o_hazard
);
    logic [DEPTH-1:0] w_match;
    logic [DEPTH-1:0] w_fwdable;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // x0 is hardwired zero, so it never creates a dependence.
            assign w_match[gi] = i_sb[gi].valid & i_sb[gi].wen &
                                 (i_sb[gi].rd == i_rs) & (i_rs != '0) &
                                 i_used & i_valid;
            // A load's data only exists from LOAD_READY onwards.
            assign w_fwdable[gi] = (FWD_EN != 0) &
                                   (~i_sb[gi].is_load | (gi >= LOAD_READY));
        end
    endgenerate

    // Scan oldest to youngest so the youngest matching entry has the last word.
    always_comb begin
        o_sel    = SEL_W'(FWD_REGFILE);
        o_hazard = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                if (w_fwdable[k]) begin
                    o_sel    = SEL_W'(fwd_sel_of(k));
                    o_hazard = 1'b0;
                end else begin
                    o_sel    = SEL_W'(FWD_REGFILE);
                    o_hazard = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Scoreboard-based hazard detection and forwarding control between ID and
// the ID/EX register. Entry 0 is EX; entries shift one stage every cycle.
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int NREG       = 32,
    parameter int DEPTH      = 3,
    parameter int FWD_EN     = 1,
    parameter int LOAD_READY = 1,
    parameter int KILL_DEPTH = 1,
    parameter int REG_AW     = $clog2(NREG),
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_unit_if.slave bus
);
    sb_entry_t [DEPTH-1:0] r_sb;
    sb_entry_t [DEPTH-1:0] w_sb_next;
    logic [31:0]           r_stall_count;

    logic [SEL_W-1:0] w_sel1;
    logic [SEL_W-1:0] w_sel2;
    logic             w_haz1;
    logic             w_haz2;
    logic             w_stall;
    logic             w_issue;

    hazard_match #(
        .DEPTH(DEPTH), .FWD_EN(FWD_EN), .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)
    ) u_match_rs1 (
        .i_sb(r_sb), .i_rs(RD_W'(bus.id_rs1)), .i_used(bus.id_rs1_used),
        .i_valid(bus.id_valid), .o_sel(w_sel1), .o_hazard(w_haz1)
    );

    hazard_match #(
        .DEPTH(DEPTH), .FWD_EN(FWD_EN), .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)
    ) u_match_rs2 (
        .i_sb(r_sb), .i_rs(RD_W'(bus.id_rs2)), .i_used(bus.id_rs2_used),
        .i_valid(bus.id_valid), .o_sel(w_sel2), .o_hazard(w_haz2)
    );

    // A taken branch kills the ID instruction, so it can never stall.
    assign w_stall = bus.id_valid & ~bus.flush & (w_haz1 | w_haz2);
    assign w_issue = bus.id_valid & ~w_stall & ~bus.flush;

    assign bus.stall       = w_stall;
    assign bus.issue       = w_issue;
    assign bus.fwd_sel_rs1 = (w_stall | ~bus.id_valid) ? SEL_W'(FWD_REGFILE) : w_sel1;
    assign bus.fwd_sel_rs2 = (w_stall | ~bus.id_valid) ? SEL_W'(FWD_REGFILE) : w_sel2;
    assign bus.stall_count = r_stall_count;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_next
            if (gi == 0) begin : g_head
                // Issued instruction enters EX; otherwise a bubble goes in.
                assign w_sb_next[gi] = w_issue ?
                    {1'b1, RD_W'(bus.id_rd), bus.id_wen, bus.id_is_load} : SB_BUBBLE;
            end else begin : g_body
                // Young entries on the wrong path are killed before they advance.
                assign w_sb_next[gi] = (bus.flush & ((gi - 1) < KILL_DEPTH)) ?
                    SB_BUBBLE : r_sb[gi-1];
            end
        end
    endgenerate

    // Scoreboard shift register; the oldest entry simply falls off the end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_next;
        end
    end

    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

endmodule
